hyp_feeder: RTL and testbench

Upstream operand feeder for the hypotenuse evaluator (y = isqrt(a²+b²), start/busy handshake). It buffers incoming (a, b) operand pairs in a small FIFO and issues them one at a time to the evaluator, holding the operands stable for the whole operation. It captures each result when the evaluator goes idle and presents it on a valid/ready output port. It also counts completed operations.

---
 rtl/hyp_pkg.sv | 13 +
 rtl/hyp_fifo.sv | 60 ++++++
 rtl/hyp_feeder.sv | 102 ++++++++++
 tb/tb_hyp_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyp_pkg.sv
// Shared types and widths for the hypotenuse operand feeder.
package hyp_pkg;

    localparam int OPW = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hyp_fifo.sv
// Register FIFO holding packed {a,b} operand pairs awaiting issue.
module hyp_fifo
    import hyp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * OPW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hyp_feeder.sv
// Feeds buffered (a,b) pairs to the hypotenuse evaluator one at a time and
// holds each result on a valid/ready port until consumed.
module hyp_feeder
    import hyp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OPW-1:0]   in_a_bi,
    input  logic [OPW-1:0]   in_b_bi,
    output logic [OPW-1:0]   ev_a_bo,
    output logic [OPW-1:0]   ev_b_bo,
    output logic             ev_start_o,
    input  logic             ev_busy_i,
    input  logic [OPW-1:0]   ev_y_bi,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [OPW-1:0]   res_bo,
    output logic [CNT_W-1:0] done_cnt_bo
);

    localparam int AW = $clog2(DEPTH);

    state_t             state;
    logic [AW:0]        fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*OPW-1:0]   head;
    logic               push;
    logic               pop;

    assign in_ready_o = (fifo_count < (AW + 1)'(DEPTH));
    assign push       = in_valid_i && !fifo_full;
    // An unconsumed result blocks the next issue so it can never be overwritten.
    assign pop        = (state == IDLE) && !fifo_empty && !res_valid_o;

    hyp_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * OPW)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push      (push),
        .push_data ({in_a_bi, in_b_bi}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            ev_a_bo     <= '0;
            ev_b_bo     <= '0;
            ev_start_o  <= 1'b0;
            res_bo      <= '0;
            res_valid_o <= 1'b0;
            done_cnt_bo <= '0;
        end else begin
            ev_start_o <= 1'b0;
            if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        {ev_a_bo, ev_b_bo} <= head;
                        ev_start_o         <= 1'b1;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ev_busy_i) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Operands stay on ev_a_bo/ev_b_bo until the evaluator drops busy.
                    if (!ev_busy_i) begin
                        res_bo      <= ev_y_bi;
                        res_valid_o <= 1'b1;
                        done_cnt_bo <= done_cnt_bo + CNT_W'(1);
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyp_feeder.sv
// Bench for hyp_feeder: behavioural evaluator, queue-based reference model
// and directed operand sequences with hand-computed hypotenuse results.
module tb_hyp_feeder;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic [7:0]  in_a_bi;
    logic [7:0]  in_b_bi;
    logic        ev_busy_i = 1'b0;
    logic [7:0]  ev_y_bi = 8'd0;
    logic        res_ready_i;

    logic        in_ready_o;
    logic [7:0]  ev_a_bo;
    logic [7:0]  ev_b_bo;
    logic        ev_start_o;
    logic        res_valid_o;
    logic [7:0]  res_bo;
    logic [15:0] done_cnt_bo;

    logic        in_ready2;
    logic [7:0]  ev_a2;
    logic [7:0]  ev_b2;
    logic        ev_start2;
    logic        res_valid2;
    logic [7:0]  res2;
    logic [1:0]  done_cnt2;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    hyp_feeder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_a_bi     (in_a_bi),
        .in_b_bi     (in_b_bi),
        .ev_a_bo     (ev_a_bo),
        .ev_b_bo     (ev_b_bo),
        .ev_start_o  (ev_start_o),
        .ev_busy_i   (ev_busy_i),
        .ev_y_bi     (ev_y_bi),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_bo      (res_bo),
        .done_cnt_bo (done_cnt_bo)
    );

    // Narrow-counter copy sharing every input, used to observe counter wrap.
    hyp_feeder #(.DEPTH(DEPTH), .CNT_W(2)) dut_w2 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready2),
        .in_a_bi     (in_a_bi),
        .in_b_bi     (in_b_bi),
        .ev_a_bo     (ev_a2),
        .ev_b_bo     (ev_b2),
        .ev_start_o  (ev_start2),
        .ev_busy_i   (ev_busy_i),
        .ev_y_bi     (ev_y_bi),
        .res_valid_o (res_valid2),
        .res_ready_i (res_ready_i),
        .res_bo      (res2),
        .done_cnt_bo (done_cnt2)
    );

    function automatic int isqrt(int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    // Evaluator: busy from the cycle after start, result after LAT busy cycles.
    int         ev_rem = 0;
    logic [7:0] ev_la = 8'd0;
    logic [7:0] ev_lb = 8'd0;
    always @(negedge clk) begin
        if (!rst_i) begin
            ev_busy_i = 1'b0;
            ev_rem    = 0;
            ev_y_bi   = 8'd0;
        end else if (ev_start_o) begin
            ev_busy_i = 1'b1;
            ev_rem    = LAT;
            ev_la     = ev_a_bo;
            ev_lb     = ev_b_bo;
        end else if (ev_busy_i) begin
            ev_rem--;
            if (ev_rem == 0) begin
                ev_busy_i = 1'b0;
                ev_y_bi   = 8'(isqrt(int'(ev_la) * int'(ev_la) + int'(ev_lb) * int'(ev_lb)));
            end
        end
    end

    always @(negedge clk) begin
        if (ev_start_o) start_cnt++;
    end

    // Reference model: queue of pending pairs, the operation in flight
    // (0 none, 1 start cycle, 2 awaiting busy, 3 awaiting completion) and the result slot.
    logic [15:0] mq[$];
    int          op_phase = 0;
    logic [7:0]  m_a = 8'd0;
    logic [7:0]  m_b = 8'd0;
    logic [7:0]  m_res = 8'd0;
    bit          m_rv = 1'b0;
    int          m_cnt = 0;
    bit          armed = 1'b0;
    int          consumed[$];
    int          cnt2_seq[$];

    always @(posedge clk) begin
        bit take_in;
        bit issue;
        bit finish;
        bit drain;
        if (!rst_i) begin
            mq.delete();
            op_phase = 0;
            m_a = 8'd0;
            m_b = 8'd0;
            m_res = 8'd0;
            m_rv = 1'b0;
            m_cnt = 0;
            armed = 1'b1;
        end else if (armed) begin
            take_in = in_valid_i && (mq.size() < DEPTH);
            issue   = (op_phase == 0) && (mq.size() > 0) && !m_rv;
            finish  = (op_phase == 3) && !ev_busy_i;
            drain   = m_rv && res_ready_i;
            if (drain) begin
                consumed.push_back(int'(m_res));
                m_rv = 1'b0;
            end
            if (issue) {m_a, m_b} = mq.pop_front();
            if (take_in) mq.push_back({in_a_bi, in_b_bi});
            if (finish) begin
                m_res = ev_y_bi;
                m_rv  = 1'b1;
                m_cnt++;
                cnt2_seq.push_back(m_cnt % 4);
            end
            if (issue) op_phase = 1;
            else if (op_phase == 1) op_phase = 2;
            else if (op_phase == 2 && ev_busy_i) op_phase = 3;
            else if (finish) op_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", in_ready_o, mq.size() < DEPTH);
            check("ev_start", ev_start_o, op_phase == 1);
            check("ev_a", ev_a_bo, m_a);
            check("ev_b", ev_b_bo, m_b);
            check("res_valid", res_valid_o, m_rv);
            check("res", res_bo, m_res);
            check("done_cnt", done_cnt_bo, m_cnt & 16'hFFFF);
            check("w2_in_ready", in_ready2, mq.size() < DEPTH);
            check("w2_ev_start", ev_start2, op_phase == 1);
            check("w2_ev_a", ev_a2, m_a);
            check("w2_ev_b", ev_b2, m_b);
            check("w2_res_valid", res_valid2, m_rv);
            check("w2_res", res2, m_res);
            check("w2_done_cnt", done_cnt2, m_cnt % 4);
        end
    end

    logic [7:0] pa [8];
    logic [7:0] pb [8];

    // Offers pa/pb[0..n-1] back to back; reports the first index that saw in_ready low.
    task automatic push_list(input int n, output int first_refused);
        int i;
        int guard;
        i = 0;
        guard = 0;
        first_refused = -1;
        while (i < n && guard < 300) begin
            in_valid_i = 1'b1;
            in_a_bi    = pa[i];
            in_b_bi    = pb[i];
            if (in_ready_o) i++;
            else if (first_refused < 0) first_refused = i;
            @(negedge clk);
            guard++;
        end
        in_valid_i = 1'b0;
        check("push_accepted", i, n);
    endtask

    task automatic wait_result(input int exp_y, input int exp_cnt);
        int guard;
        guard = 0;
        while (!res_valid_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("result_timeout", guard < 200, 1);
        check("result_value", res_bo, exp_y);
        check("result_count", done_cnt_bo, exp_cnt);
    endtask

    initial begin
        int fr;
        int guard;
        int sc;
        int exp_res [7];
        int exp_w2 [7];
        exp_res = '{5, 10, 10, 13, 0, 17, 29};
        exp_w2  = '{1, 2, 3, 0, 1, 2, 3};

        rst_i = 1'b0;
        in_valid_i = 1'b0;
        in_a_bi = 8'd0;
        in_b_bi = 8'd0;
        res_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_done_cnt", done_cnt_bo, 0);
        check("rst_ev_start", ev_start_o, 0);
        check("rst_ev_a", ev_a_bo, 0);
        check("rst_res", res_bo, 0);
        rst_i = 1'b1;
        @(negedge clk);

        // Single operation, result left pending.
        pa[0] = 8'd3; pb[0] = 8'd4;
        push_list(1, fr);
        wait_result(5, 1);
        check("single_starts", start_cnt, 1);
        check("single_w2_cnt", done_cnt2, 1);

        // Pending result must block the next issue.
        pa[0] = 8'd6; pb[0] = 8'd8;
        push_list(1, fr);
        repeat (20) @(negedge clk);
        check("stall_starts", start_cnt, 1);
        check("stall_res", res_bo, 5);
        res_ready_i = 1'b1;
        guard = 0;
        while (res_valid_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        wait_result(10, 2);
        res_ready_i = 1'b0;
        check("stall_release_starts", start_cnt, 2);

        // Burst into a stalled feeder: four fit, the fifth waits for a pop.
        pa[0] = 8'd6;  pb[0] = 8'd8;
        pa[1] = 8'd5;  pb[1] = 8'd12;
        pa[2] = 8'd0;  pb[2] = 8'd0;
        pa[3] = 8'd8;  pb[3] = 8'd15;
        pa[4] = 8'd20; pb[4] = 8'd21;
        fork
            push_list(5, fr);
            begin
                repeat (8) @(negedge clk);
                res_ready_i = 1'b1;
            end
        join
        check("burst_first_refused", fr, 4);
        guard = 0;
        while (!(m_cnt == 7 && !m_rv) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("burst_timeout", guard < 400, 1);
        check("burst_done_cnt", done_cnt_bo, 7);
        check("burst_w2_cnt", done_cnt2, 3);
        check("burst_starts", start_cnt, 7);
        check("consumed_count", consumed.size(), 7);
        check("w2_seq_count", cnt2_seq.size(), 7);
        for (int k = 0; k < 7 && k < consumed.size() && k < cnt2_seq.size(); k++) begin
            check("consumed_order", consumed[k], exp_res[k]);
            check("w2_wrap_seq", cnt2_seq[k], exp_w2[k]);
        end

        // Reset during WAIT_DONE with two pairs still queued.
        pa[0] = 8'd1; pb[0] = 8'd1;
        pa[1] = 8'd2; pb[1] = 8'd2;
        pa[2] = 8'd3; pb[2] = 8'd3;
        push_list(3, fr);
        guard = 0;
        while (op_phase != 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midop_reached", guard < 100, 1);
        check("midop_queued", mq.size(), 2);
        check("midop_ev_a", ev_a_bo, 1);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_rst_ev_a", ev_a_bo, 0);
        check("midop_rst_ev_b", ev_b_bo, 0);
        check("midop_rst_start", ev_start_o, 0);
        check("midop_rst_res_valid", res_valid_o, 0);
        check("midop_rst_res", res_bo, 0);
        check("midop_rst_cnt", done_cnt_bo, 0);
        check("midop_rst_in_ready", in_ready_o, 1);
        rst_i = 1'b1;
        sc = start_cnt;
        repeat (30) @(negedge clk);
        check("post_rst_starts", start_cnt, sc);
        check("post_rst_res_valid", res_valid_o, 0);
        check("post_rst_cnt", done_cnt_bo, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
